sum_round_robin_arbiter: RTL and testbench

Shares one registered `a + b` adder stage between `n_req` requesters, each presenting an operand pair on its own valid/ready port. The block uses a round-robin policy, grants at most one requester per cycle, and tags each sum with the winning requester index. It sits between several per-requester operand FIFOs and a single sum FIFO, replacing one dedicated adder per requester.

---
 rtl/sum_arb_pkg.sv | 19 +
 rtl/round_robin_arbiter.sv | 37 +++
 rtl/sum_round_robin_arbiter.sv | 97 +++++++++
 tb/tb_sum_round_robin_arbiter.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/sum_arb_pkg.sv
// Shared definitions for the round-robin adder arbiter: tag-width helper and
// the registered result record.
package sum_arb_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_N_REQ = 4;

  // Tag width for n requesters; a single requester still needs one bit.
  function automatic int id_w_of(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  typedef struct packed {
    logic [DEF_WIDTH-1:0]         data;
    logic                         carry;
    logic [$clog2(DEF_N_REQ)-1:0] id;
  } sum_rec_t;

endpackage

// File: rtl/round_robin_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping around; grant is suppressed when en is low.
module round_robin_arbiter
  import sum_arb_pkg::*;
#(
  parameter int n_req = 4,
  localparam int id_w = id_w_of(n_req)
) (
  input  logic [n_req-1:0] req,
  input  logic [id_w-1:0]  ptr,
  input  logic             en,
  output logic [n_req-1:0] gnt,
  output logic [id_w-1:0]  gnt_id
);

  always_comb begin
    logic            found;
    logic [id_w-1:0] idx;
    int              slot;
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = '0;
    slot   = 0;
    for (int k = 0; k < n_req; k++) begin
      slot = int'(ptr) + k;
      if (slot >= n_req) slot = slot - n_req;
      idx = id_w'(slot);
      if (!found && req[idx]) begin
        found  = 1'b1;
        gnt_id = idx;
      end
    end
    if (en && found) gnt[gnt_id] = 1'b1;
  end

endmodule

// File: rtl/sum_round_robin_arbiter.sv
// One registered a+b adder shared round-robin among n_req valid/ready
// requesters; each result carries its carry-out and the winner's index.
module sum_round_robin_arbiter
  import sum_arb_pkg::*;
#(
  parameter int width = 8,
  parameter int n_req = 4,
  localparam int id_w = id_w_of(n_req)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [n_req-1:0]       req_valid,
  output logic [n_req-1:0]       req_ready,
  input  logic [n_req*width-1:0] req_a,
  input  logic [n_req*width-1:0] req_b,
  output logic                   sum_valid,
  input  logic                   sum_ready,
  output logic [width-1:0]       sum_data,
  output logic                   sum_carry,
  output logic [id_w-1:0]        sum_id
);

  typedef struct packed {
    logic [width-1:0] data;
    logic             carry;
    logic [id_w-1:0]  id;
  } rec_t;

  rec_t            r_out;
  logic            r_valid;
  logic [id_w-1:0] r_ptr;

  logic [n_req-1:0] w_gnt;
  logic [id_w-1:0]  w_gnt_id;
  logic             w_can_load;
  logic             w_xfer;
  logic [width-1:0] w_a;
  logic [width-1:0] w_b;
  logic [width:0]   w_sum;
  logic [id_w-1:0]  w_ptr_next;

  function automatic logic [width:0] add_wide(input logic [width-1:0] a,
                                              input logic [width-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  // Gating with rst keeps every grant low for the whole time reset is held.
  assign w_can_load = !r_valid || sum_ready;

  round_robin_arbiter #(.n_req(n_req)) u_arb (
    .req    (req_valid),
    .ptr    (r_ptr),
    .en     (w_can_load && rst),
    .gnt    (w_gnt),
    .gnt_id (w_gnt_id)
  );

  assign w_xfer    = |(w_gnt & req_valid);
  assign req_ready = w_gnt;

  always_comb begin
    w_a = '0;
    w_b = '0;
    for (int i = 0; i < n_req; i++) begin
      if (w_gnt_id == id_w'(i)) begin
        w_a = req_a[i*width +: width];
        w_b = req_b[i*width +: width];
      end
    end
  end

  assign w_sum      = add_wide(w_a, w_b);
  assign w_ptr_next = (w_gnt_id == id_w'(n_req - 1)) ? '0 : w_gnt_id + 1'b1;

  // Output stage: load on transfer, otherwise drain when downstream accepts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out   <= '0;
      r_valid <= 1'b0;
      r_ptr   <= '0;
    end else if (w_xfer) begin
      r_out.data  <= w_sum[width-1:0];
      r_out.carry <= w_sum[width];
      r_out.id    <= w_gnt_id;
      r_valid     <= 1'b1;
      r_ptr       <= w_ptr_next;
    end else if (r_valid && sum_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign sum_valid = r_valid;
  assign sum_data  = r_out.data;
  assign sum_carry = r_out.carry;
  assign sum_id    = r_out.id;

endmodule

// File: tb/tb_sum_round_robin_arbiter.sv
// Bench for sum_round_robin_arbiter: single-shot vector table, directed
// multi-cycle sequences and randomized traffic against a behavioural model.
module tb_sum_round_robin_arbiter;

  localparam int W  = 8;
  localparam int N  = 4;
  localparam int IW = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic           sum_valid;
  logic           sum_ready;
  logic [W-1:0]   sum_data;
  logic           sum_carry;
  logic [IW-1:0]  sum_id;

  int n_chk  = 0;
  int n_pass = 0;

  // Behavioural model state
  int m_ptr;
  bit m_valid;
  int m_data;
  int m_carry;
  int m_id;

  sum_round_robin_arbiter #(.width(W), .n_req(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .sum_valid (sum_valid),
    .sum_ready (sum_ready),
    .sum_data  (sum_data),
    .sum_carry (sum_carry),
    .sum_id    (sum_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [N*W-1:0] pack(input logic [W-1:0] x0, input logic [W-1:0] x1,
                                          input logic [W-1:0] x2, input logic [W-1:0] x3);
    return {x3, x2, x1, x0};
  endfunction

  // Round-robin choice written as a plain circular search.
  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_valid = 0; m_data = 0; m_carry = 0; m_id = 0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    req_valid = '0; req_a = '0; req_b = '0; sum_ready = 1'b1;
    model_reset();
    @(posedge clk); @(posedge clk);
    #1;
    chk("rst_valid", sum_valid, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_data", sum_data, 0);
    chk("rst_id", sum_id, 0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // One model-checked cycle: grant before the edge, outputs after it.
  task automatic cycle(input string tag);
    int w;
    int s;
    logic [N-1:0] er;
    #1;
    w  = (!m_valid || sum_ready) ? pick(req_valid, m_ptr) : -1;
    er = (w >= 0) ? (N'(1) << w) : '0;
    chk({tag, "_ready"}, req_ready, er);
    @(posedge clk);
    if (w >= 0) begin
      s = int'(req_a[w*W +: W]) + int'(req_b[w*W +: W]);
      m_data = s % 256; m_carry = s / 256; m_id = w; m_valid = 1;
      m_ptr = (w + 1) % N;
    end else if (m_valid && sum_ready) begin
      m_valid = 0;
    end
    #1;
    chk({tag, "_valid"}, sum_valid, m_valid);
    chk({tag, "_ptr"}, dut.r_ptr, m_ptr);
    if (m_valid) begin
      chk({tag, "_data"}, sum_data, m_data);
      chk({tag, "_carry"}, sum_carry, m_carry);
      chk({tag, "_id"}, sum_id, m_id);
    end
  endtask

  typedef struct {
    logic [N-1:0]   v;
    logic [N*W-1:0] a;
    logic [N*W-1:0] b;
    logic [N-1:0]   exp_rdy;
    logic [W-1:0]   exp_data;
    logic           exp_carry;
    logic [IW-1:0]  exp_id;
    int             exp_ptr;
  } vec_t;

  vec_t vecs[5];
  logic [W-1:0] held_data;
  logic [IW-1:0] held_id;

  initial begin
    vecs[0] = '{4'b0100, pack(8'h00, 8'h00, 8'h05, 8'h00), pack(8'h00, 8'h00, 8'h07, 8'h00),
                4'b0100, 8'h0C, 1'b0, 2'd2, 3};
    vecs[1] = '{4'b0001, pack(8'hFF, 8'h00, 8'h00, 8'h00), pack(8'h02, 8'h00, 8'h00, 8'h00),
                4'b0001, 8'h01, 1'b1, 2'd0, 1};
    vecs[2] = '{4'b1010, pack(8'h00, 8'h10, 8'h00, 8'h44), pack(8'h00, 8'h20, 8'h00, 8'h55),
                4'b0010, 8'h30, 1'b0, 2'd1, 2};
    vecs[3] = '{4'b1000, pack(8'h00, 8'h00, 8'h00, 8'h80), pack(8'h00, 8'h00, 8'h00, 8'h80),
                4'b1000, 8'h00, 1'b1, 2'd3, 0};
    vecs[4] = '{4'b1111, pack(8'h7F, 8'h01, 8'h02, 8'h03), pack(8'h01, 8'h01, 8'h01, 8'h01),
                4'b0001, 8'h80, 1'b0, 2'd0, 1};

    // Single-transaction vectors, each from a fresh reset (ptr = 0).
    for (int i = 0; i < 5; i++) begin
      do_reset();
      req_valid = vecs[i].v; req_a = vecs[i].a; req_b = vecs[i].b; sum_ready = 1'b1;
      #1;
      chk("vec_ready", req_ready, vecs[i].exp_rdy);
      @(posedge clk); #1;
      chk("vec_valid", sum_valid, 1);
      chk("vec_data", sum_data, vecs[i].exp_data);
      chk("vec_carry", sum_carry, vecs[i].exp_carry);
      chk("vec_id", sum_id, vecs[i].exp_id);
      chk("vec_ptr", dut.r_ptr, vecs[i].exp_ptr);
      req_valid = '0;
      @(posedge clk); #1;
      chk("vec_drain", sum_valid, 0);
    end

    // Round-robin order with all requesters valid: 0,1,2,3,0,... no gaps.
    do_reset();
    req_valid = 4'b1111; req_a = pack(8'h01, 8'h02, 8'h03, 8'h04);
    req_b = pack(8'h10, 8'h20, 8'h30, 8'h40);
    for (int i = 0; i < 8; i++) begin
      cycle("rr");
      chk("rr_order", sum_id, i % N);
    end

    // Backpressure: three stalled cycles, then load on the draining edge.
    sum_ready = 1'b0;
    cycle("bp_load");
    held_data = sum_data; held_id = sum_id;
    for (int i = 0; i < 3; i++) begin
      cycle("bp_stall");
      chk("bp_hold_data", sum_data, held_data);
      chk("bp_hold_id", sum_id, held_id);
    end
    sum_ready = 1'b1;
    cycle("bp_release");
    chk("bp_next_id", sum_id, (held_id + 1) % N);

    // Skip idle requesters: move ptr to 1, then only 0 and 3 valid.
    do_reset();
    req_valid = 4'b0001; req_a = pack(8'h01, 8'h00, 8'h00, 8'h09);
    req_b = pack(8'h01, 8'h00, 8'h00, 8'h09);
    cycle("skip_pre");
    req_valid = 4'b1001;
    cycle("skip_a");
    chk("skip_first", sum_id, 3);
    cycle("skip_b");
    chk("skip_second", sum_id, 0);

    // Reset asserted mid-operation drops the pending result at once.
    req_valid = 4'b1111;
    cycle("mid_pre");
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", sum_valid, 0);
    chk("mid_rst_ready", req_ready, 0);
    chk("mid_rst_data", sum_data, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    req_valid = 4'b1010;
    cycle("mid_post");
    chk("mid_post_id", sum_id, 1);

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      req_valid = N'($urandom_range(0, 15));
      req_a     = $urandom;
      req_b     = $urandom;
      sum_ready = ($urandom_range(0, 3) != 0);
      cycle("rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
